// File: rtl/tiny_pkg.sv
// Shared types and constants for the RAM arbiter.
package tiny_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
module rr_pick2
  import tiny_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_idx
);

  // Single request wins outright; a tie goes to the non-owner.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = REQ_CPU;
    if (req0 && req1) grant_idx = ~last_owner;
    else if (req1)    grant_idx = REQ_LDR;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates CPU and loader accesses onto the single-port RAM's MI/RI protocol.
module ram_arbiter
  import tiny_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_ack,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             ldr_req,
  input  logic             ldr_we,
  input  logic [WIDTH-1:0] ldr_addr,
  input  logic [WIDTH-1:0] ldr_wdata,
  output logic             ldr_ack,
  output logic [WIDTH-1:0] ldr_rdata,
  output logic             mem_mi,
  output logic             mem_ri,
  output logic [WIDTH-1:0] mem_write,
  input  logic [WIDTH-1:0] mem_read,
  output logic             busy,
  output logic             owner
);

  arb_state_t             state, state_nxt;
  logic                   owner_q;
  logic                   we_q;
  logic [WIDTH-1:0]       addr_q;
  logic [WIDTH-1:0]       wdata_q;
  logic [1:0][WIDTH-1:0]  rdata_q;
  logic                   grant_valid;
  logic                   grant_idx;

  rr_pick2 u_pick (
    .req0        (cpu_req),
    .req1        (ldr_req),
    .last_owner  (owner_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register plus grant latching; requester inputs are only sampled in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= REQ_LDR;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_valid) begin
        owner_q <= grant_idx;
        we_q    <= (grant_idx == REQ_LDR) ? ldr_we    : cpu_we;
        addr_q  <= (grant_idx == REQ_LDR) ? ldr_addr  : cpu_addr;
        wdata_q <= (grant_idx == REQ_LDR) ? ldr_wdata : cpu_wdata;
      end
      if (state == DATA && !we_q) rdata_q[owner_q] <= mem_read;
    end
  end

  // Fixed four-step sequence once a grant is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ADDR;
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs; reset masks strobes so an aborted access never writes or acks.
  always_comb begin
    mem_mi    = 1'b0;
    mem_ri    = 1'b0;
    mem_write = '0;
    cpu_ack   = 1'b0;
    ldr_ack   = 1'b0;
    if (!reset) begin
      case (state)
        ADDR: begin
          mem_mi    = 1'b1;
          mem_write = addr_q;
        end
        DATA: begin
          if (we_q) begin
            mem_ri    = 1'b1;
            mem_write = wdata_q;
          end
        end
        DONE: begin
          cpu_ack = (owner_q == REQ_CPU);
          ldr_ack = (owner_q == REQ_LDR);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign owner     = owner_q;
  assign cpu_rdata = rdata_q[REQ_CPU];
  assign ldr_rdata = rdata_q[REQ_LDR];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized checks of ram_arbiter against a transaction-level model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_ack, ldr_ack;
  logic [15:0] cpu_rdata, ldr_rdata;
  logic        mem_mi, mem_ri;
  logic [15:0] mem_write, mem_read;
  logic        busy, owner;

  ram_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_mi(mem_mi), .mem_ri(mem_ri), .mem_write(mem_write), .mem_read(mem_read),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench RAM: MAR loads on MI, RI writes MAR location, read is combinational.
  logic [15:0] ram [256];
  logic [15:0] mar;
  logic        mem_clr, pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h0;
      mar <= 16'h0;
    end else begin
      if (pre_en) ram[pre_addr] <= pre_data;
      if (mem_mi) mar <= mem_write;
      if (mem_ri) ram[mar[7:0]] <= mem_write;
    end
  end
  assign mem_read = ram[mar[7:0]];

  // Ack log for the contention window.
  bit ack_log_en = 1'b0;
  bit ack_who[$];
  int ack_at[$];
  always @(negedge clk) if (ack_log_en) begin
    if (cpu_ack) begin ack_who.push_back(1'b0); ack_at.push_back(cyc); end
    if (ldr_ack) begin ack_who.push_back(1'b1); ack_at.push_back(cyc); end
  end

  // Transaction-level model state.
  logic [15:0] exp_ram [256];
  logic [15:0] exp_rd [2];
  bit          exp_owner;
  bit          p_valid [2];
  bit          p_we [2];
  logic [15:0] p_addr [2];
  logic [15:0] p_wdata [2];

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_ports();
    cpu_req = p_valid[0]; cpu_we = p_we[0]; cpu_addr = p_addr[0]; cpu_wdata = p_wdata[0];
    ldr_req = p_valid[1]; ldr_we = p_we[1]; ldr_addr = p_addr[1]; ldr_wdata = p_wdata[1];
  endtask

  task automatic new_req(input bit who);
    p_valid[who] = 1'b1;
    p_we[who]    = 1'($urandom);
    p_addr[who]  = 16'($urandom_range(0, 255));
    p_wdata[who] = 16'($urandom);
  endtask

  // Called at a negedge in IDLE with at least one pending request; returns at the next IDLE negedge.
  task automatic run_access(input bit scramble, output bit w);
    chk1("idle_busy", busy, 1'b0);
    drive_ports();
    w = (p_valid[0] && p_valid[1]) ? ~exp_owner : p_valid[1];
    @(negedge clk);
    chk1("addr_mi", mem_mi, 1'b1);
    chk1("addr_ri", mem_ri, 1'b0);
    chk16("addr_bus", mem_write, p_addr[w]);
    chk1("owner", owner, w);
    chk1("busy", busy, 1'b1);
    if (scramble) begin
      if (w == 1'b0) begin cpu_addr = p_addr[0] + 16'h10; cpu_wdata = ~p_wdata[0]; cpu_we = ~p_we[0]; end
      else           begin ldr_addr = p_addr[1] + 16'h10; ldr_wdata = ~p_wdata[1]; ldr_we = ~p_we[1]; end
    end
    @(negedge clk);
    chk1("data_mi", mem_mi, 1'b0);
    chk1("data_ri", mem_ri, p_we[w]);
    chk16("data_bus", mem_write, p_we[w] ? p_wdata[w] : 16'h0);
    chk1("data_acks", cpu_ack | ldr_ack, 1'b0);
    @(negedge clk);
    if (p_we[w]) exp_ram[p_addr[w][7:0]] = p_wdata[w];
    else         exp_rd[w] = exp_ram[p_addr[w][7:0]];
    chk1("cpu_ack", cpu_ack, w == 1'b0);
    chk1("ldr_ack", ldr_ack, w == 1'b1);
    chk16("cpu_rdata", cpu_rdata, exp_rd[0]);
    chk16("ldr_rdata", ldr_rdata, exp_rd[1]);
    chk1("done_strobes", mem_mi | mem_ri, 1'b0);
    exp_owner  = w;
    p_valid[w] = 1'b0;
    drive_ports();
    @(negedge clk);
  endtask

  initial begin
    bit w;
    int mism;
    for (int i = 0; i < 256; i++) exp_ram[i] = 16'h0;
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    exp_owner = 1'b1;
    pre_en = 1'b0; pre_addr = 8'h0; pre_data = 16'h0;

    // Reset held two cycles with both requests high.
    reset = 1'b1; mem_clr = 1'b1;
    p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 16'h0005; p_wdata[0] = 16'h0;
    p_valid[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 16'h0006; p_wdata[1] = 16'h0;
    drive_ports();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("rst_mi", mem_mi, 1'b0);
      chk1("rst_ri", mem_ri, 1'b0);
      chk16("rst_bus", mem_write, 16'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b1);
      chk1("rst_acks", cpu_ack | ldr_ack, 1'b0);
      chk16("rst_cpu_rdata", cpu_rdata, 16'h0);
      chk16("rst_ldr_rdata", ldr_rdata, 16'h0);
    end
    reset = 1'b0; mem_clr = 1'b0;

    // First tie after reset goes to the CPU, then the loader.
    run_access(1'b0, w);
    run_access(1'b0, w);

    // CPU write 13 <- 7.
    p_valid[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 16'h000D; p_wdata[0] = 16'h0007;
    run_access(1'b0, w);
    chk16("ram13", ram[13], 16'h0007);

    // Loader read of preloaded 0xC8.
    pre_en = 1'b1; pre_addr = 8'hC8; pre_data = 16'h00FF;
    exp_ram[8'hC8] = 16'h00FF;
    @(negedge clk);
    pre_en = 1'b0;
    p_valid[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 16'h00C8; p_wdata[1] = 16'h0;
    run_access(1'b0, w);
    chk16("ldr_read_c8", ldr_rdata, 16'h00FF);

    // Contention: both held, each re-requests right after its ack.
    ack_who.delete(); ack_at.delete();
    ack_log_en = 1'b1;
    new_req(1'b0); new_req(1'b1);
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, w);
      new_req(w);
    end
    ack_log_en = 1'b0;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0; drive_ports();
    chk16("cont_ack_count", 16'(ack_who.size()), 16'd4);
    if (ack_who.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk1("cont_order", ack_who[i], 1'(i % 2));
        if (i > 0) chk16("cont_spacing", 16'(ack_at[i] - ack_at[i-1]), 16'd4);
      end
    end
    @(negedge clk);

    // Reset during DATA of a CPU write.
    p_valid[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 16'h0030; p_wdata[0] = 16'h0055;
    drive_ports();
    @(negedge clk);
    chk1("abort_addr_mi", mem_mi, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    p_valid[0] = 1'b0; drive_ports();
    #1;
    chk1("abort_ri_in_reset", mem_ri, 1'b0);
    chk1("abort_ack_in_reset", cpu_ack, 1'b0);
    @(posedge clk); #1;
    chk1("abort_idle", busy, 1'b0);
    chk1("abort_ri_after", mem_ri, 1'b0);
    chk1("abort_no_ack", cpu_ack, 1'b0);
    chk1("abort_owner", owner, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    exp_owner = 1'b1;
    chk16("abort_ram30", ram[8'h30], 16'h0);

    // Input change during ADDR is ignored.
    p_valid[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 16'h0010; p_wdata[0] = 16'h1234;
    run_access(1'b1, w);
    chk16("ign_ram10", ram[8'h10], 16'h1234);
    chk16("ign_ram20", ram[8'h20], exp_ram[8'h20]);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      for (int r = 0; r < 2; r++)
        if (!p_valid[r] && $urandom_range(0, 1) == 1) new_req(1'(r));
      if (!p_valid[0] && !p_valid[1]) begin
        drive_ports();
        chk1("rand_idle_busy", busy, 1'b0);
        chk1("rand_idle_mi", mem_mi, 1'b0);
        @(negedge clk);
      end else begin
        run_access(1'($urandom_range(0, 3) == 0), w);
      end
    end

    // Final RAM image against the model.
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) mism++;
    chk16("ram_image", 16'(mism), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
